// File: rtl/rf_write_arbiter_if.sv
// Handshake and status bundle for rf_write_arbiter: two write requesters, the issue/flush
// scoreboard controls, the pending-write vector and the register-file write port.
interface rf_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic                   i_req0_valid;
    logic [ADDR_W-1:0]      i_req0_rd;
    logic [DATA_W-1:0]      i_req0_data;
    logic                   o_req0_ready;

    logic                   i_req1_valid;
    logic [ADDR_W-1:0]      i_req1_rd;
    logic [DATA_W-1:0]      i_req1_data;
    logic                   o_req1_ready;

    logic                   i_issue_valid;
    logic [ADDR_W-1:0]      i_issue_rd;
    logic                   i_flush;
    logic [2**ADDR_W-1:0]   o_busy;

    logic                   o_rf_we;
    logic [ADDR_W-1:0]      o_rf_rd;
    logic [DATA_W-1:0]      o_rf_wdata;

    modport master (
        output i_req0_valid, i_req0_rd, i_req0_data,
        output i_req1_valid, i_req1_rd, i_req1_data,
        output i_issue_valid, i_issue_rd, i_flush,
        input  o_req0_ready, o_req1_ready, o_busy,
        input  o_rf_we, o_rf_rd, o_rf_wdata
    );

    modport slave (
        input  i_req0_valid, i_req0_rd, i_req0_data,
        input  i_req1_valid, i_req1_rd, i_req1_data,
        input  i_issue_valid, i_issue_rd, i_flush,
        output o_req0_ready, o_req1_ready, o_busy,
        output o_rf_we, o_rf_rd, o_rf_wdata
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter (ALU vs load unit) with a per-register pending-write scoreboard.
// Define RF_ARB_FIXED_PRIO_EN to give requester 1 fixed priority instead of round-robin.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic               i_clk,
    input logic               i_rst_n,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic              gnt0;
    logic              gnt1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    logic               rf_we_d, rf_we_q;
    logic [ADDR_W-1:0]  rf_rd_d, rf_rd_q;
    logic [DATA_W-1:0]  rf_wdata_d, rf_wdata_q;
    logic [NumRegs-1:0] busy_d, busy_q;

`ifndef RF_ARB_FIXED_PRIO_EN
    // 1 means requester 1 was granted last, so requester 0 wins the next contention.
    logic last_d, last_q;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            if (bus.i_req0_valid && bus.i_req1_valid) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                gnt1 = 1'b1;
`else
                gnt0 = last_q;
                gnt1 = !last_q;
`endif
            end else begin
                gnt0 = bus.i_req0_valid;
                gnt1 = bus.i_req1_valid;
            end
        end
    end

    assign xfer     = gnt0 | gnt1;
    assign sel_rd   = gnt1 ? bus.i_req1_rd : bus.i_req0_rd;
    assign sel_data = gnt1 ? bus.i_req1_data : bus.i_req0_data;

    assign bus.o_req0_ready = gnt0;
    assign bus.o_req1_ready = gnt1;

    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        busy_d     = busy_q;
        if (xfer) begin
            rf_we_d          = (sel_rd != '0);
            rf_rd_d          = sel_rd;
            rf_wdata_d       = sel_data;
            busy_d[sel_rd]   = 1'b0;
        end
        // Applied after the clear so a same-register issue wins.
        if (bus.i_issue_valid && (bus.i_issue_rd != '0)) begin
            busy_d[bus.i_issue_rd] = 1'b1;
        end
        if (bus.i_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

`ifndef RF_ARB_FIXED_PRIO_EN
    assign last_d = xfer ? gnt1 : last_q;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
`ifndef RF_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.o_rf_we    = rf_we_q;
    assign bus.o_rf_rd    = rf_rd_q;
    assign bus.o_rf_wdata = rf_wdata_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the arbitration and scoreboard rules.
module tb_rf_write_arbiter;
`ifdef RF_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail = 0;

    // Reference model state
    int          m_last = 1;
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_busy = '0;

    rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check readies mid-cycle, advance model, check registered outputs.
    task automatic step(input logic rst, input logic v0, input logic [4:0] rd0,
                        input logic [31:0] d0, input logic v1, input logic [4:0] rd1,
                        input logic [31:0] d1, input logic iv, input logic [4:0] ird,
                        input logic fl);
        int         g;
        logic [4:0] wrd;
        rst_n             = rst;
        bus.i_req0_valid  = v0;
        bus.i_req0_rd     = rd0;
        bus.i_req0_data   = d0;
        bus.i_req1_valid  = v1;
        bus.i_req1_rd     = rd1;
        bus.i_req1_data   = d1;
        bus.i_issue_valid = iv;
        bus.i_issue_rd    = ird;
        bus.i_flush       = fl;
        #1;
        if (!rst) g = -1;
        else if (v0 && v1) g = FixedPrio ? 1 : 1 - m_last;
        else if (v0) g = 0;
        else if (v1) g = 1;
        else g = -1;
        chk("ready0", bus.o_req0_ready, (g == 0) ? 1 : 0);
        chk("ready1", bus.o_req1_ready, (g == 1) ? 1 : 0);

        if (!rst) begin
            m_we = 1'b0; m_rd = '0; m_wdata = '0; m_busy = '0; m_last = 1;
        end else begin
            m_we = 1'b0;
            if (g >= 0) begin
                wrd     = (g == 1) ? rd1 : rd0;
                m_rd    = wrd;
                m_wdata = (g == 1) ? d1 : d0;
                m_we    = (wrd != 5'd0);
                m_last  = g;
                m_busy[wrd] = 1'b0;
            end
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
            if (fl) m_busy = '0;
        end

        @(posedge clk);
        #1;
        chk("rf_we", bus.o_rf_we, m_we);
        chk("rf_rd", bus.o_rf_rd, m_rd);
        chk("rf_wdata", bus.o_rf_wdata, m_wdata);
        chk("busy", bus.o_busy, m_busy);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_req0_valid = 1'b0; bus.i_req0_rd = '0; bus.i_req0_data = '0;
        bus.i_req1_valid = 1'b0; bus.i_req1_rd = '0; bus.i_req1_data = '0;
        bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0; bus.i_flush = 1'b0;
        @(posedge clk);
        #1;

        // Reset with a request and an issue present: no write, nothing busy
        step(1'b0, 1'b1, 5'd4, 32'h1234, 1'b1, 5'd6, 32'h5678, 1'b1, 5'd4, 1'b0);
        step(1'b0, 1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);

        // Single requester 0 write
        step(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("single_wdata", bus.o_rf_wdata, 64'hDEADBEEF);
        idle();

        // Contention for four cycles
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 5'd1, 32'hA0 + 32'(i), 1'b1, 5'd2, 32'hB0 + 32'(i),
                 1'b0, 5'd0, 1'b0);

        // Issue rd5, then transfer rd5 two cycles later
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0);
        idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 1'b0);
        idle();

        // Same-cycle issue and transfer on rd7
        step(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        chk("set_wins_busy7", 64'(bus.o_busy[7]), 64'd1);

        // Write to x0 is accepted but produces no write
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 1'b0);

        // Build busy = 0xF0, then flush with same-cycle issue rd9 and a transfer
        for (int r = 4; r < 7; r++)
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0);
        chk("pre_flush_busy", bus.o_busy, 64'hF0);
        step(1'b1, 1'b1, 5'd10, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1);
        chk("flush_busy", bus.o_busy, 64'd0);

        // Reset mid-contention, then first contention after release
        step(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 1'b0);
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 32'h33, 1'b1, 5'd2, 32'h44, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 32'h35, 1'b1, 5'd2, 32'h46, 1'b0, 5'd0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) != 0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 15) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
